// File: rtl/m_mem_access_if.sv
// Data-memory req/ack bus between the M-stage access unit (master) and the
// variable-latency data memory (slave).
interface m_mem_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/m_mem_access.sv
// M-stage data-memory access unit: decodes load/store, drives the req/ack bus, stalls the
// pipeline while an access is outstanding. Optional macro ALIGN_CHECK_EN adds misalign exceptions.
module m_mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr_in,
   input  logic [31:0]          pc_in,
   input  logic [31:0]          AO_in,
   input  logic [31:0]          RD2_in,
   m_mem_access_if.master       bus,
   output logic                 stall,
   output logic [31:0]          load_data,
   output logic                 load_valid,
   output logic                 bus_err,
   output logic [31:0]          err_pc
`ifdef ALIGN_CHECK_EN
   ,
   output logic                 exc_adel,
   output logic                 exc_ades
`endif
);

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [5:0]       opcode;
   logic             is_load;
   logic             is_store;
   logic             is_word;
   logic             is_half;
   logic             memop;
   logic             misalign;
   logic             issue;
   logic             req;
   logic             timeout_hit;
   logic [31:0]      ld_word_p0;

   function automatic logic [3:0] lane_en(input logic [5:0] op, input logic [1:0] lane);
      case (op)
         OP_SW:   lane_en = 4'b1111;
         OP_SH:   lane_en = lane[1] ? 4'b1100 : 4'b0011;
         OP_SB:   lane_en = 4'b0001 << lane;
         default: lane_en = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_word(input logic [5:0] op, input logic [31:0] rd2);
      case (op)
         OP_SW:   store_word = rd2;
         OP_SH:   store_word = {2{rd2[15:0]}};
         OP_SB:   store_word = {4{rd2[7:0]}};
         default: store_word = 32'h0;
      endcase
   endfunction

   // Lane-select the read word and sign/zero-extend to 32 bits.
   function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [31:0]        shifted;
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      shifted = word >> {lane, 3'b000};
      byte_s  = signed'(shifted[7:0]);
      half_s  = signed'(lane[1] ? word[31:16] : word[15:0]);
      case (op)
         OP_LW:   load_extend = word;
         OP_LB:   load_extend = 32'(byte_s);
         OP_LBU:  load_extend = {24'h0, shifted[7:0]};
         OP_LH:   load_extend = 32'(half_s);
         OP_LHU:  load_extend = {16'h0, half_s};
         default: load_extend = 32'h0;
      endcase
   endfunction

   always_comb begin
      opcode   = instr_in[31:26];
      is_load  = 1'b0;
      is_store = 1'b0;
      is_word  = 1'b0;
      is_half  = 1'b0;
      case (opcode)
         OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LB, OP_LBU:       is_load  = 1'b1;
         OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
         OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
         OP_SB:               is_store = 1'b1;
         default:       ;
      endcase
      memop = is_load | is_store;
   end

`ifdef ALIGN_CHECK_EN
   assign misalign = (is_word & (AO_in[1:0] != 2'b00)) | (is_half & AO_in[0]);
`else
   assign misalign = 1'b0;
`endif

   assign issue       = memop & ~misalign;
   assign req         = reset & (((state == IDLE) & issue) | (state == WAIT));
   assign timeout_hit = (TIMEOUT != 0) && ((32'(count) + 32'd1) == TIMEOUT);
   assign ld_word_p0  = load_extend(opcode, AO_in[1:0], bus.mem_rdata);

   assign bus.mem_req    = req;
   assign bus.mem_we     = req & is_store;
   assign bus.mem_addr   = reset ? {AO_in[31:2], 2'b00} : 32'h0;
   assign bus.mem_byteen = reset ? lane_en(opcode, AO_in[1:0]) : 4'b0000;
   assign bus.mem_wdata  = reset ? store_word(opcode, RD2_in) : 32'h0;
   assign stall          = reset & memop & (state != DONE);

   // ---- stage boundary: access FSM and registered results ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         load_data  <= 32'h0;
         load_valid <= 1'b0;
         bus_err    <= 1'b0;
         err_pc     <= 32'h0;
`ifdef ALIGN_CHECK_EN
         exc_adel   <= 1'b0;
         exc_ades   <= 1'b0;
`endif
      end else begin
         load_valid <= 1'b0;
         bus_err    <= 1'b0;
`ifdef ALIGN_CHECK_EN
         exc_adel   <= 1'b0;
         exc_ades   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (memop) begin
                  if (misalign) begin
                     state  <= DONE;
                     err_pc <= pc_in;
`ifdef ALIGN_CHECK_EN
                     exc_adel <= is_load;
                     exc_ades <= is_store;
`endif
                  end else if (bus.mem_ack) begin
                     state <= DONE;
                     if (is_load) begin
                        load_data  <= ld_word_p0;
                        load_valid <= 1'b1;
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  state <= DONE;
                  if (is_load) begin
                     load_data  <= ld_word_p0;
                     load_valid <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state   <= DONE;
                  bus_err <= 1'b1;
                  err_pc  <= pc_in;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
